dtag_bist_ctrl: RTL and testbench



---
 rtl/dtag_bist_pkg.sv | 27 ++
 rtl/dtag_bist_addr_gen.sv | 103 ++++++++++
 rtl/dtag_bist_ctrl.sv | 135 +++++++++++++
 tb/tb_dtag_bist_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtag_bist_pkg.sv
// Shared state encoding and March-C- element table for the data-cache tag BIST sequencer.
// DTAG_BIST_CHECKERBOARD_EN selects a second march pass with checkerboard background.
package dtag_bist_pkg;

    localparam int ELEM_CNT = 6;
    localparam int PASS_LEN = 5120;

`ifdef DTAG_BIST_CHECKERBOARD_EN
    localparam int N_PASS = 2;
`else
    localparam int N_PASS = 1;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Bit i describes march element i: E0 w0 | E1 r0w1 | E2 r1w0 | E3 r0w1 | E4 r1w0 | E5 r0
    localparam logic [ELEM_CNT-1:0] ELEM_DOWN      = 6'b111000;
    localparam logic [ELEM_CNT-1:0] ELEM_FIRST_RD  = 6'b111110;
    localparam logic [ELEM_CNT-1:0] ELEM_FIRST_VAL = 6'b010100;
    localparam logic [ELEM_CNT-1:0] ELEM_TWO_OP    = 6'b011110;

endpackage

// File: rtl/dtag_bist_addr_gen.sv
// Up/down address counter with element and read/write phase sequencing and last-op detect.
// DTAG_BIST_CHECKERBOARD_EN adds the pass bit that repeats the march with checkerboard data.
module dtag_bist_addr_gen
    import dtag_bist_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int N_ELEM = ELEM_CNT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    output logic [ADDR_W-1:0] adr,
    output logic              op_rd,
    output logic              op_val,
    output logic              pass,
    output logic              last_op
);
    localparam logic [ADDR_W-1:0] ADR_MAX   = '1;
    localparam logic [2:0]        LAST_ELEM = 3'(N_ELEM - 1);

    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [2:0]        elem_q, elem_d, elem_nxt;
    logic              phase_q, phase_d;
    logic              pass_q, last_pass;
    logic              elem_down, two_op, adr_end, elem_end, last_elem;

`ifdef DTAG_BIST_CHECKERBOARD_EN
    logic pass_d;

    assign last_pass = pass_q;

    always_comb begin
        pass_d = pass_q;
        if (start) begin
            pass_d = 1'b0;
        end else if (step && elem_end && last_elem) begin
            pass_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_q <= 1'b0;
        end else begin
            pass_q <= pass_d;
        end
    end
`else
    assign pass_q    = 1'b0;
    assign last_pass = 1'b1;
`endif

    always_comb begin
        elem_down = ELEM_DOWN[elem_q];
        two_op    = ELEM_TWO_OP[elem_q];
        op_rd     = ~phase_q & ELEM_FIRST_RD[elem_q];
        op_val    = ELEM_FIRST_VAL[elem_q] ^ phase_q;
        adr_end   = elem_down ? (adr_q == '0) : (adr_q == ADR_MAX);
        elem_end  = adr_end & (phase_q | ~two_op);
        last_elem = (elem_q == LAST_ELEM);
        last_op   = elem_end & last_elem & last_pass;
        elem_nxt  = last_elem ? 3'd0 : elem_q + 3'd1;

        adr_d   = adr_q;
        elem_d  = elem_q;
        phase_d = phase_q;
        if (start) begin
            adr_d   = '0;
            elem_d  = 3'd0;
            phase_d = 1'b0;
        end else if (step) begin
            if (two_op && !phase_q) begin
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                if (!adr_end) begin
                    adr_d = elem_down ? adr_q - ADDR_W'(1) : adr_q + ADDR_W'(1);
                end else begin
                    // Jump straight to the next element's start so up->down keeps 511.
                    elem_d = elem_nxt;
                    adr_d  = ELEM_DOWN[elem_nxt] ? ADR_MAX : '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr_q   <= '0;
            elem_q  <= 3'd0;
            phase_q <= 1'b0;
        end else begin
            adr_q   <= adr_d;
            elem_q  <= elem_d;
            phase_q <= phase_d;
        end
    end

    assign adr  = adr_q;
    assign pass = pass_q;

endmodule

// File: rtl/dtag_bist_ctrl.sv
// March-C- BIST sequencer for the dcache tag/status arrays with sticky DONE/ERROR/FAIL status.
// DTAG_BIST_CHECKERBOARD_EN (via dtag_bist_pkg) enables a second, checkerboard-background pass.
//
// state | meaning
// IDLE  | arrays released, waiting for mode[0]
// RUN   | one march operation per cycle
// DRAIN | one cycle to sample the final registered read error
// DONE  | sequence finished, held until mode[0] drops
module dtag_bist_ctrl
    import dtag_bist_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int N_ELEM = ELEM_CNT
) (
    input  logic              clk,
    input  logic              bist_reset,
    input  logic [1:0]        mode,
    input  logic              test_mode,
    input  logic              rrdtag_0_error,
    input  logic              rrdtag_1_error,
    input  logic              rr512x5_error,
    output logic [ADDR_W-1:0] bist_adr,
    output logic              bist_we,
    output logic              inverse,
    output logic              background,
    output logic              no_comp,
    output logic              end_seq,
    output logic              bist_on,
    output logic              errn_on,
    output logic              rrdtag_0_enable,
    output logic              rrdtag_1_enable,
    output logic              rr512x5_enable,
    output logic              done,
    output logic              error,
    output logic [2:0]        fail
);
    state_e            state_q, state_d;
    logic              cmp_vld_q, cmp_vld_d;
    logic [2:0]        fail_q, fail_d;
    logic [2:0]        err_in;
    logic              start, run, on, stop;
    logic [ADDR_W-1:0] adr;
    logic              op_rd, op_val, pass, last_op;

    dtag_bist_addr_gen #(
        .ADDR_W (ADDR_W),
        .N_ELEM (N_ELEM)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (bist_reset),
        .start   (start),
        .step    (run),
        .adr     (adr),
        .op_rd   (op_rd),
        .op_val  (op_val),
        .pass    (pass),
        .last_op (last_op)
    );

    assign err_in = {rr512x5_error, rrdtag_1_error, rrdtag_0_error};
    assign run    = (state_q == RUN);
    assign on     = run | (state_q == DRAIN);
    assign start  = (state_q == IDLE) & mode[0];
    assign stop   = (mode == 2'b11) & cmp_vld_q & (|err_in);

    always_comb begin
        state_d   = state_q;
        cmp_vld_d = run & op_rd;
        fail_d    = fail_q;
        if (start) begin
            fail_d = 3'b000;
        end else if (cmp_vld_q) begin
            fail_d = fail_q | err_in;
        end

        unique case (state_q)
            IDLE:  if (mode[0]) state_d = RUN;
            RUN: begin
                if (!mode[0])     state_d = IDLE;
                else if (stop)    state_d = DONE;
                else if (last_op) state_d = DRAIN;
            end
            DRAIN: state_d = mode[0] ? DONE : IDLE;
            DONE:  if (!mode[0]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge bist_reset) begin
        if (bist_reset) begin
            state_q   <= IDLE;
            cmp_vld_q <= 1'b0;
            fail_q    <= 3'b000;
        end else begin
            state_q   <= state_d;
            cmp_vld_q <= cmp_vld_d;
            fail_q    <= fail_d;
        end
    end

    // Scan forces the reset-value interface while the sequencer keeps running.
    always_comb begin
        bist_adr        = on ? adr : '0;
        bist_we         = run & ~op_rd;
        inverse         = run & op_val;
        background      = on & pass;
        no_comp         = ~(run & op_rd);
        end_seq         = run & last_op;
        bist_on         = on;
        errn_on         = cmp_vld_q;
        rrdtag_0_enable = on;
        rrdtag_1_enable = on;
        rr512x5_enable  = on;
        done            = (state_q == DONE);
        error           = |fail_q;
        fail            = fail_q;
        if (test_mode) begin
            bist_adr        = '0;
            bist_we         = 1'b0;
            inverse         = 1'b0;
            background      = 1'b0;
            no_comp         = 1'b1;
            end_seq         = 1'b0;
            bist_on         = 1'b0;
            errn_on         = 1'b0;
            rrdtag_0_enable = 1'b0;
            rrdtag_1_enable = 1'b0;
            rr512x5_enable  = 1'b0;
            done            = 1'b0;
            error           = 1'b0;
            fail            = 3'b000;
        end
    end

endmodule

// File: tb/tb_dtag_bist_ctrl.sv
// Scoreboard bench for dtag_bist_ctrl: per-run expectations are queued by the stimulus and
// checked by a monitor when bist_on drops; the monitor also checks every BIST cycle against a march model.
`timescale 1ns/1ps
module tb_dtag_bist_ctrl;

`ifdef DTAG_BIST_CHECKERBOARD_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif
    localparam int RUN_LEN = 5120 * NPASS;

    logic       clk = 1'b0;
    logic       bist_reset;
    logic [1:0] mode;
    logic       test_mode;
    logic       rrdtag_0_error, rrdtag_1_error, rr512x5_error;
    logic [8:0] bist_adr;
    logic       bist_we, inverse, background, no_comp, end_seq, bist_on, errn_on;
    logic       rrdtag_0_enable, rrdtag_1_enable, rr512x5_enable;
    logic       done, error;
    logic [2:0] fail;

    dtag_bist_ctrl dut (
        .clk             (clk),
        .bist_reset      (bist_reset),
        .mode            (mode),
        .test_mode       (test_mode),
        .rrdtag_0_error  (rrdtag_0_error),
        .rrdtag_1_error  (rrdtag_1_error),
        .rr512x5_error   (rr512x5_error),
        .bist_adr        (bist_adr),
        .bist_we         (bist_we),
        .inverse         (inverse),
        .background      (background),
        .no_comp         (no_comp),
        .end_seq         (end_seq),
        .bist_on         (bist_on),
        .errn_on         (errn_on),
        .rrdtag_0_enable (rrdtag_0_enable),
        .rrdtag_1_enable (rrdtag_1_enable),
        .rr512x5_enable  (rr512x5_enable),
        .done            (done),
        .error           (error),
        .fail            (fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    on_cycles;
        int    done;
        int    fail;
        int    error;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cur_edge = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Independent march model: RUN cycle rc (1-based) -> address, read flag, data value, background.
    function automatic void model_op(input int rc, output int adr, output bit rd,
                                     output bit val, output bit bg);
        int k, k2, e, j;
        k  = (rc - 1) % 5120;
        bg = ((rc - 1) >= 5120);
        if (k < 512) begin
            adr = k; rd = 1'b0; val = 1'b0;
        end else if (k < 4608) begin
            k2  = k - 512;
            e   = 1 + k2 / 1024;
            j   = k2 % 1024;
            rd  = ((j % 2) == 0);
            adr = (e <= 2) ? j / 2 : 511 - j / 2;
            val = ((e == 2) || (e == 4)) ^ !rd;
        end else begin
            adr = 511 - (k - 4608); rd = 1'b1; val = 1'b0;
        end
    endfunction

    initial begin : monitor
        int         rc, run_bad, m_adr;
        bit         m_rd, m_val, m_bg, prev_rd, prev_on;
        logic [17:0] act_v, exp_v, mask_v;
        exp_t       e;
        rc = 0; run_bad = 0; prev_rd = 1'b0; prev_on = 1'b0;
        forever begin
            @(negedge clk);
            if (bist_on) begin
                rc++;
                act_v = {bist_adr, bist_we, inverse, no_comp, end_seq, errn_on, background,
                         rrdtag_0_enable, rrdtag_1_enable, rr512x5_enable};
                if (rc <= RUN_LEN) begin
                    model_op(rc, m_adr, m_rd, m_val, m_bg);
                    exp_v  = {9'(m_adr), !m_rd, m_val, !m_rd, (rc == RUN_LEN), prev_rd, m_bg, 3'b111};
                    mask_v = '1;
                    prev_rd = m_rd;
                end else begin
                    exp_v  = {9'd0, 1'b0, 1'b0, 1'b1, 1'b0, prev_rd, 1'b0, 3'b111};
                    mask_v = {9'd0, 5'b11111, 1'b0, 3'b111};
                    prev_rd = 1'b0;
                end
                if ((act_v & mask_v) != exp_v) begin
                    run_bad++;
                    if (run_bad == 1)
                        $display("note: first sequence difference at bist cycle %0d got %h want %h",
                                 rc, act_v & mask_v, exp_v);
                end
            end else if (prev_on) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_empty: run ended after %0d cycles with no expectation queued", rc);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_on_cycles"}, rc, e.on_cycles);
                    check({e.name, "_done"}, int'(done), e.done);
                    check({e.name, "_fail"}, int'(fail), e.fail);
                    check({e.name, "_error"}, int'(error), e.error);
                    check({e.name, "_seq_bad_cycles"}, run_bad, 0);
                end
                rc = 0; run_bad = 0; prev_rd = 1'b0;
            end
            prev_on = bist_on;
        end
    end

    task automatic start_run(input logic [1:0] m);
        @(negedge clk);
        mode = m;
        @(posedge clk);
        cur_edge = 0;
    endtask

    // Move to just after the edge that opens RUN cycle c.
    task automatic goto_cycle(input int c);
        while (cur_edge < c - 1) begin
            @(posedge clk);
            cur_edge++;
        end
        #1;
    endtask

    task automatic pulse_err(input int which);
        case (which)
            0: rrdtag_0_error = 1'b1;
            1: rrdtag_1_error = 1'b1;
            default: rr512x5_error = 1'b1;
        endcase
        @(posedge clk);
        cur_edge++;
        #1;
        rrdtag_0_error = 1'b0;
        rrdtag_1_error = 1'b0;
        rr512x5_error  = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_done_seen"}, int'(done), 1);
    endtask

    task automatic go_idle();
        @(negedge clk);
        mode = 2'b00;
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #800_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bist_reset = 1'b0; mode = 2'b00; test_mode = 1'b0;
        rrdtag_0_error = 1'b0; rrdtag_1_error = 1'b0; rr512x5_error = 1'b0;
        #2 bist_reset = 1'b1;
        #1;
        check("rst_no_comp", int'(no_comp), 1);
        check("rst_bist_on", int'(bist_on), 0);
        check("rst_done", int'(done), 0);
        check("rst_fail", int'(fail), 0);
        check("rst_adr", int'(bist_adr), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) bist_reset = 1'b0;

        // Reset in RUN cycle 301: 300 BIST cycles seen, outputs back to reset values at once.
        sb_q.push_back('{"reset_mid", 300, 0, 0, 0});
        start_run(2'b01);
        goto_cycle(301);
        bist_reset = 1'b1;
        mode = 2'b00;
        #1;
        check("midrst_bist_on", int'(bist_on), 0);
        check("midrst_no_comp", int'(no_comp), 1);
        check("midrst_we", int'(bist_we), 0);
        check("midrst_fail", int'(fail), 0);
        @(negedge clk) bist_reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_stays_idle", int'(bist_on), 0);

        // Clean run: exact done latency, then scan forcing while in DONE.
        sb_q.push_back('{"clean", RUN_LEN + 1, 1, 0, 0});
        start_run(2'b01);
        goto_cycle(RUN_LEN + 1);
        check("clean_drain_done_low", int'(done), 0);
        check("clean_drain_bist_on", int'(bist_on), 1);
        goto_cycle(RUN_LEN + 2);
        check("clean_done_latency", int'(done), 1);
        check("clean_error", int'(error), 0);
        test_mode = 1'b1;
        #1;
        check("scan_done_forced", int'(done), 0);
        check("scan_no_comp_forced", int'(no_comp), 1);
        test_mode = 1'b0;
        #1;
        check("scan_done_restored", int'(done), 1);
        go_idle();

        // Tag set 1 error after E2 read of address 37 (RUN cycle 1611), mode 01 continues.
        sb_q.push_back('{"err_tag1", RUN_LEN + 1, 1, 3'b010, 1});
        start_run(2'b01);
        goto_cycle(1612);
        pulse_err(1);
        wait_done("err_tag1", RUN_LEN + 10);
        go_idle();

        // Errors in cycles after writes (E0 cycle 100, after E1 write at 514) are ignored.
        sb_q.push_back('{"ignored", RUN_LEN + 1, 1, 0, 0});
        start_run(2'b01);
        goto_cycle(100);
        pulse_err(2);
        goto_cycle(515);
        pulse_err(2);
        wait_done("ignored", RUN_LEN + 10);
        go_idle();

        // Stop on first error: E1 read of address 5 at RUN cycle 523, error in 524.
        sb_q.push_back('{"stop_on_err", 524, 1, 3'b001, 1});
        start_run(2'b11);
        goto_cycle(524);
        pulse_err(0);
        check("stop_done", int'(done), 1);
        check("stop_bist_on", int'(bist_on), 0);
        check("stop_fail", int'(fail), 1);
        go_idle();

        // Abort at RUN cycle 1000 keeps captured fail; restart clears it.
        sb_q.push_back('{"abort", 1000, 0, 3'b001, 1});
        start_run(2'b01);
        goto_cycle(524);
        pulse_err(0);
        goto_cycle(1000);
        mode = 2'b00;
        goto_cycle(1001);
        check("abort_bist_on", int'(bist_on), 0);
        check("abort_done", int'(done), 0);
        repeat (3) @(negedge clk);
        check("abort_fail_kept", int'(fail), 1);
        check("abort_idle", int'(bist_on), 0);

        sb_q.push_back('{"restart", RUN_LEN + 1, 1, 0, 0});
        start_run(2'b01);
        #1;
        check("restart_fail_cleared", int'(fail), 0);
        wait_done("restart", RUN_LEN + 10);
        go_idle();

        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
